// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: executes loads/stores on a word-wide dmem bus
// with no byte enables (SB/SH via read-modify-write) and builds the write-back packet.
module mem_access_stage #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    output logic [31:0] dmem_addr,
    inout  wire  [31:0] dmem_data,
    output logic        dmem_wen,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest,
    output logic        wb_wen,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE} state_t;

    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  lane_reg, lane_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [4:0]  dest_reg, dest_next;
    logic [15:0] store_data_reg, store_data_next;
    logic        is_store_reg, is_store_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] addr_reg, addr_next;
    logic        wb_valid_reg, wb_valid_next;
    logic [31:0] wb_result_reg, wb_result_next;
    logic [4:0]  wb_dest_reg, wb_dest_next;
    logic        wb_wen_reg, wb_wen_next;
    logic        err_reg, err_next;

    // Alignment and legality decode of the op offered by EX
    logic half_op, word_op, misaligned, illegal, access_err;
    assign half_op    = (ex_funct3[1:0] == 2'b01);
    assign word_op    = (ex_funct3[1:0] == 2'b10);
    assign misaligned = (half_op && ex_alu_result[0]) ||
                        (word_op && (ex_alu_result[1:0] != 2'b00));
    assign illegal    = (ex_is_load && ex_is_store) ||
                        (ex_is_load && (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11)) ||
                        (ex_is_store && (ex_funct3 > 3'd2));
    assign access_err = (ex_is_load || ex_is_store) && (misaligned || illegal);

    // Load extraction from the sampled bus word
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;
    assign rd_byte = dmem_data[{lane_reg, 3'b000} +: 8];
    assign rd_half = lane_reg[1] ? dmem_data[31:16] : dmem_data[15:0];

    always_comb begin
        load_value = dmem_data;
        case (funct3_reg)
            3'd0:    load_value = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_value = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_value = {24'd0, rd_byte};
            3'd5:    load_value = {16'd0, rd_half};
            default: load_value = dmem_data;
        endcase
    end

    // Sub-word store merge: funct3_reg[0] distinguishes SH (1) from SB (0)
    logic [31:0] merged_word;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] lane_src;
        assign lane_hit = funct3_reg[0] ? (lane_reg[1] == LANE[1]) : (lane_reg == LANE);
        assign lane_src = funct3_reg[0] ? store_data_reg[8*(gi%2) +: 8] : store_data_reg[7:0];
        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : dmem_data[8*gi +: 8];
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        lane_next       = lane_reg;
        funct3_next     = funct3_reg;
        dest_next       = dest_reg;
        store_data_next = store_data_reg;
        is_store_next   = is_store_reg;
        wdata_next      = wdata_reg;
        addr_next       = addr_reg;
        wb_valid_next   = 1'b0;
        wb_result_next  = wb_result_reg;
        wb_dest_next    = wb_dest_reg;
        wb_wen_next     = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ex_valid) begin
                    if (access_err) begin
                        wb_valid_next = 1'b1;
                        wb_dest_next  = ex_dest;
                        err_next      = 1'b1;
                    end else if (ex_is_load || ex_is_store) begin
                        addr_next       = {ex_alu_result[31:2], 2'b00};
                        lane_next       = ex_alu_result[1:0];
                        funct3_next     = ex_funct3;
                        dest_next       = ex_dest;
                        store_data_next = ex_store_data[15:0];
                        is_store_next   = ex_is_store;
                        cnt_next        = 2'd0;
                        if (ex_is_store && word_op) begin
                            wdata_next = ex_store_data;
                            state_next = WRITE;
                        end else begin
                            state_next = RD_WAIT;
                        end
                    end else begin
                        wb_valid_next  = 1'b1;
                        wb_result_next = ex_alu_result;
                        wb_dest_next   = ex_dest;
                        wb_wen_next    = (ex_dest != 5'd0);
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_reg == LAST_CNT) begin
                    if (is_store_reg) begin
                        wdata_next = merged_word;
                        state_next = WRITE;
                    end else begin
                        wb_valid_next  = 1'b1;
                        wb_result_next = load_value;
                        wb_dest_next   = dest_reg;
                        wb_wen_next    = (dest_reg != 5'd0);
                        state_next     = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            WRITE: begin
                wb_valid_next = 1'b1;
                wb_dest_next  = dest_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            lane_reg       <= 2'd0;
            funct3_reg     <= 3'd0;
            dest_reg       <= 5'd0;
            store_data_reg <= 16'd0;
            is_store_reg   <= 1'b0;
            wdata_reg      <= 32'd0;
            addr_reg       <= 32'd0;
            wb_valid_reg   <= 1'b0;
            wb_result_reg  <= 32'd0;
            wb_dest_reg    <= 5'd0;
            wb_wen_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            lane_reg       <= lane_next;
            funct3_reg     <= funct3_next;
            dest_reg       <= dest_next;
            store_data_reg <= store_data_next;
            is_store_reg   <= is_store_next;
            wdata_reg      <= wdata_next;
            addr_reg       <= addr_next;
            wb_valid_reg   <= wb_valid_next;
            wb_result_reg  <= wb_result_next;
            wb_dest_reg    <= wb_dest_next;
            wb_wen_reg     <= wb_wen_next;
            err_reg        <= err_next;
        end
    end

    assign ex_ready     = (state_reg == IDLE);
    assign dmem_wen     = (state_reg == WRITE);
    assign dmem_addr    = addr_reg;
    assign dmem_data    = dmem_wen ? wdata_reg : 32'bz;
    assign wb_valid     = wb_valid_reg;
    assign wb_result    = wb_result_reg;
    assign wb_dest      = wb_dest_reg;
    assign wb_wen       = wb_wen_reg;
    assign misalign_err = err_reg;

endmodule
